msd_dram_cmd_sched: RTL and testbench

- Synthesizable DDR5 command scheduler for one channel of the MSD memory controller.
- Sits between the 16-entry request queue and the DIMM command bus. Accepts one request at a time over a valid/ready handshake and decodes the 36-bit address.
- Issues the two-cycle ACT, RD/WR and PRE command sequence under a closed-page policy.
- Enforces tRCD, tRTP, tCWL+tBURST+tWR and per-bank tRP across all 32 banks.

---
 rtl/msd_dram_cmd_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_msd_dram_cmd_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msd_dram_cmd_sched.sv
// ---------------------------------------------------------------------------
// msd_dram_cmd_sched
//   DDR5 command scheduler for one channel of the MSD memory controller.
//   Takes one request at a time from the request queue. For each request it
//   issues the ACT0/ACT1, RD0/RD1 or WR0/WR1, then PRE sequence under a
//   closed-page policy. It honours tRCD, tRTP, write recovery and a per-bank
//   tRP across all 32 banks.
//
//   Ports:
//     clk, rst_n            DIMM command clock, async active-low reset
//     req_valid/req_ready   request handshake (ready only while idle)
//     req_op                0 read, 1 write, 2 ifetch (read), 3 illegal
//     req_addr              36-bit physical address, decoded at accept
//     cmd_valid, cmd_type   command strobe and encoding (0..6)
//     cmd_bg/bank/row/col   latched target of the current request
//     req_done              pulse in the PRE cycle
//     req_err               pulse the cycle after an illegal op is accepted
//
//   Optional build macro MSD_SCHED_STATS_EN adds the saturating counters
//   stat_rd, stat_wr and stat_rp_stall. Command timing is the same in both
//   builds.
// ---------------------------------------------------------------------------
module msd_dram_cmd_sched #(
  parameter int T_RP    = 39,
  parameter int T_RCD   = 39,
  parameter int T_RTP   = 18,
  parameter int T_CWL   = 38,
  parameter int T_BURST = 8,
  parameter int T_WR    = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        req_done,
  output logic        req_err
`ifdef MSD_SCHED_STATS_EN
  ,
  output logic [31:0] stat_rd,
  output logic [31:0] stat_wr,
  output logic [31:0] stat_rp_stall
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RP, S_ACT0, S_ACT1, S_WAIT_RCD,
    S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE
  } state_t;

  localparam logic [2:0] CT_ACT0 = 3'd0;
  localparam logic [2:0] CT_ACT1 = 3'd1;
  localparam logic [2:0] CT_RD0  = 3'd2;
  localparam logic [2:0] CT_RD1  = 3'd3;
  localparam logic [2:0] CT_WR0  = 3'd4;
  localparam logic [2:0] CT_WR1  = 3'd5;
  localparam logic [2:0] CT_PRE  = 3'd6;

  // Loads are "distance minus one": the counter is loaded in the issuing
  // cycle and the next command goes out once it has counted down to zero.
  localparam logic [7:0] RCD_LD = 8'(T_RCD - 1);
  localparam logic [7:0] RTP_LD = 8'(T_RTP - 1);
  localparam logic [7:0] WRP_LD = 8'(T_CWL + T_BURST + T_WR - 1);
  localparam logic [7:0] RP_LD  = 8'(T_RP - 1);

  state_t      state;
  state_t      next_state;
  logic        is_wr;
  logic [7:0]  dly_cnt;
  logic [7:0]  rp_timer [32];
  logic        accept;
  logic [4:0]  acc_idx;
  logic [4:0]  tgt_idx;
  logic        next_cmd_valid;
  logic [2:0]  next_cmd_type;
  logic        unused_addr_bits;

  // A timer that reads 1 now reads 0 next cycle. Testing for <= 1 lets the
  // FSM step into the command state exactly on the cycle the wait expires.
  function automatic logic expires_next(input logic [7:0] v);
    return (v <= 8'd1);
  endfunction

  assign accept  = req_valid && req_ready && (state == S_IDLE);
  assign acc_idx = {req_addr[9:7], req_addr[11:10]};
  assign tgt_idx = {cmd_bg, cmd_bank};
  // Channel bit, byte offset and unused high bits are intentionally dropped.
  assign unused_addr_bits = ^{req_addr[35:34], req_addr[6], req_addr[1:0]};

  // Next-state decision for the command sequencer.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_op == 2'd3) begin
            next_state = S_IDLE;
          end else if (expires_next(rp_timer[acc_idx])) begin
            next_state = S_ACT0;
          end else begin
            next_state = S_WAIT_RP;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT_RP: begin
        if (expires_next(rp_timer[tgt_idx])) begin
          next_state = S_ACT0;
        end else begin
          next_state = S_WAIT_RP;
        end
      end
      S_ACT0: next_state = S_ACT1;
      S_ACT1: begin
        if (expires_next(dly_cnt)) begin
          next_state = S_CAS0;
        end else begin
          next_state = S_WAIT_RCD;
        end
      end
      S_WAIT_RCD: begin
        if (expires_next(dly_cnt)) begin
          next_state = S_CAS0;
        end else begin
          next_state = S_WAIT_RCD;
        end
      end
      S_CAS0: next_state = S_CAS1;
      S_CAS1: begin
        if (expires_next(dly_cnt)) begin
          next_state = S_PRE;
        end else begin
          next_state = S_WAIT_PRE;
        end
      end
      S_WAIT_PRE: begin
        if (expires_next(dly_cnt)) begin
          next_state = S_PRE;
        end else begin
          next_state = S_WAIT_PRE;
        end
      end
      S_PRE:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Command encoding for the state about to be entered, so the bus is registered.
  always_comb begin
    next_cmd_valid = 1'b0;
    next_cmd_type  = 3'd0;
    case (next_state)
      S_ACT0: begin next_cmd_valid = 1'b1; next_cmd_type = CT_ACT0; end
      S_ACT1: begin next_cmd_valid = 1'b1; next_cmd_type = CT_ACT1; end
      S_CAS0: begin next_cmd_valid = 1'b1; next_cmd_type = is_wr ? CT_WR0 : CT_RD0; end
      S_CAS1: begin next_cmd_valid = 1'b1; next_cmd_type = is_wr ? CT_WR1 : CT_RD1; end
      S_PRE:  begin next_cmd_valid = 1'b1; next_cmd_type = CT_PRE; end
      default: begin next_cmd_valid = 1'b0; next_cmd_type = 3'd0; end
    endcase
  end

  // Sequencer state, delay counter, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      dly_cnt   <= 8'd0;
      req_ready <= 1'b0;
      req_done  <= 1'b0;
      req_err   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_type  <= 3'd0;
      cmd_bg    <= 3'd0;
      cmd_bank  <= 2'd0;
      cmd_row   <= 16'd0;
      cmd_col   <= 10'd0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == S_IDLE);
      req_done  <= (next_state == S_PRE);
      req_err   <= accept && (req_op == 2'd3);
      cmd_valid <= next_cmd_valid;
      cmd_type  <= next_cmd_type;
      if (accept) begin
        is_wr    <= (req_op == 2'd1);
        cmd_bg   <= req_addr[9:7];
        cmd_bank <= req_addr[11:10];
        cmd_row  <= req_addr[33:18];
        cmd_col  <= {req_addr[17:12], req_addr[5:2]};
      end
      if (state == S_ACT0) begin
        dly_cnt <= RCD_LD;
      end else if (state == S_CAS0) begin
        dly_cnt <= is_wr ? WRP_LD : RTP_LD;
      end else if (dly_cnt != 8'd0) begin
        dly_cnt <= dly_cnt - 8'd1;
      end
    end
  end

  // Per-bank precharge recovery timers, loaded by PRE and free-running down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rp_timer[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if ((state == S_PRE) && (tgt_idx == 5'(i))) begin
          rp_timer[i] <= RP_LD;
        end else if (rp_timer[i] != 8'd0) begin
          rp_timer[i] <= rp_timer[i] - 8'd1;
        end
      end
    end
  end

`ifdef MSD_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd       <= 32'd0;
      stat_wr       <= 32'd0;
      stat_rp_stall <= 32'd0;
    end else begin
      if ((state == S_CAS0) && !is_wr) stat_rd <= sat_inc(stat_rd);
      if ((state == S_CAS0) && is_wr)  stat_wr <= sat_inc(stat_wr);
      if ((state == S_WAIT_RP) && (rp_timer[tgt_idx] != 8'd0)) begin
        stat_rp_stall <= sat_inc(stat_rp_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_msd_dram_cmd_sched.sv
// Scoreboard bench for msd_dram_cmd_sched: stimulus predicts every command
// from the timing rules and queues it; a negedge monitor checks the bus.
module tb_msd_dram_cmd_sched;
  localparam int T_RP = 39, T_RCD = 39, T_RTP = 18;
  localparam int T_WPRE = 38 + 8 + 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [35:0] req_addr;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        req_done;
  logic        req_err;
`ifdef MSD_SCHED_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_rp_stall;
`endif

  always #5 clk = ~clk;

  msd_dram_cmd_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid),
    .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .req_done(req_done),
    .req_err(req_err)
`ifdef MSD_SCHED_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_rp_stall(stat_rp_stall)
`endif
  );

  // kind: 0..6 = command type, 7 = req_err pulse
  typedef struct {
    int cyc; int kind; int bg; int bank; int row; int col;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  free_cyc = 0;
  bit  rdy_exp = 1'b0;
  int  lastpre [32];
  int  n_checks = 0, n_fail = 0;
  int  exp_rd = 0, exp_wr = 0, exp_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare DUT outputs against the head of the expected-event queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("req_ready", req_ready, rdy_exp);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        chk("missed_event_cycle", cyc, mon_e.cyc);
      end
      if (cmd_valid || req_done || req_err) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {cmd_valid, req_done, req_err}, 0);
        end else begin
          mon_e = q.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("cmd_valid", cmd_valid, mon_e.kind != 7);
          chk("req_err", req_err, mon_e.kind == 7);
          chk("req_done", req_done, mon_e.kind == 6);
          if (mon_e.kind != 7) begin
            chk("cmd_type", cmd_type, mon_e.kind);
            chk("cmd_bg", cmd_bg, mon_e.bg);
            chk("cmd_bank", cmd_bank, mon_e.bank);
            chk("cmd_row", cmd_row, mon_e.row);
            chk("cmd_col", cmd_col, mon_e.col);
          end
        end
      end
    end
  end

  task automatic push_ev(input int c, input int k, input int bg, input int bk,
                         input int row, input int col);
    ev_t e;
    e.cyc = c; e.kind = k; e.bg = bg; e.bank = bk; e.row = row; e.col = col;
    q.push_back(e);
  endtask

  // Reference model: given an accept at cycle t, predict the whole sequence.
  task automatic model_accept(input int op, input logic [35:0] a, output int act);
    int t, bg, bk, row, col, idx, cas, pre;
    t   = cyc;
    bg  = int'((a >> 7) & 36'd7);
    bk  = int'((a >> 10) & 36'd3);
    row = int'((a >> 18) & 36'hFFFF);
    col = int'(((a >> 12) & 36'd63) * 16 + ((a >> 2) & 36'd15));
    idx = bg * 4 + bk;
    act = -1;
    if (op == 3) begin
      push_ev(t + 1, 7, 0, 0, 0, 0);
      free_cyc = t + 1;
    end else begin
      act = t + 1;
      if (lastpre[idx] + T_RP > act) act = lastpre[idx] + T_RP;
      cas = act + T_RCD;
      pre = cas + ((op == 1) ? T_WPRE : T_RTP);
      push_ev(act,     0, bg, bk, row, col);
      push_ev(act + 1, 1, bg, bk, row, col);
      push_ev(cas,     (op == 1) ? 4 : 2, bg, bk, row, col);
      push_ev(cas + 1, (op == 1) ? 5 : 3, bg, bk, row, col);
      push_ev(pre,     6, bg, bk, row, col);
      lastpre[idx] = pre;
      free_cyc = pre + 1;
      exp_stall += act - t - 1;
      if (op == 1) exp_wr++; else exp_rd++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rdy_exp = (cyc >= free_cyc);
  endtask

  // Present a request and hold it until the model says it is accepted.
  task automatic send(input int op, input logic [35:0] a, output int act);
    int guard;
    guard = 0;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_addr  = a;
    while (!rdy_exp && guard < 1000) begin
      tick();
      guard++;
    end
    model_accept(op, a, act);
    tick();
    req_valid = 1'b0;
    req_addr  = {4'hF, 32'($urandom)};
    req_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_type"}, cmd_type, 0);
    chk({tag, "_cmd_bg"}, cmd_bg, 0);
    chk({tag, "_cmd_bank"}, cmd_bank, 0);
    chk({tag, "_cmd_row"}, cmd_row, 0);
    chk({tag, "_cmd_col"}, cmd_col, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_req_err"}, req_err, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    free_cyc = cyc + 1;
    rdy_exp = 1'b0;
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int act, gap, r, g;
    logic [35:0] a;
    for (int i = 0; i < 32; i++) lastpre[i] = -1000;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = 36'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_reset();
    tick();

    // Directed: single read, write, same-bank and cross-bank back-to-back.
    send(0, 36'h0_0004_0084, act);
    send(1, 36'h0_1234_5678, act);
    send(0, 36'h0_0008_0400, act);
    send(0, 36'h0_0010_0400, act);
    send(0, 36'h0_0000_0000, act);
    send(0, 36'h0_0003_0D00, act);
    send(3, 36'h0_0000_0180, act);
    send(2, 36'h0_0000_0180, act);

    // Reset in the middle of a write; same bank must then skip the tRP wait.
    while (q.size() > 0) tick();
    send(1, 36'h0_0020_0C80, act);
    while (cyc < act + 10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    q.delete();
    for (int i = 0; i < 32; i++) lastpre[i] = -1000;
    exp_rd = 0; exp_wr = 0; exp_stall = 0;
    repeat (2) tick();
    release_reset();
    tick();
    send(1, 36'h0_0020_0C80, act);

    // Randomized traffic with bank collisions encouraged.
    for (int n = 0; n < 120; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      r = $urandom_range(0, 9);
      a[31:0]  = $urandom;
      a[35:32] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a[11:7] = 5'($urandom_range(0, 3));
      send((r < 4) ? 0 : (r < 6) ? 2 : (r < 9) ? 1 : 3, a, act);
    end

    g = 0;
    while (q.size() > 0 && g < 500) begin
      tick();
      g++;
    end
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
`ifdef MSD_SCHED_STATS_EN
    chk("stat_rd", stat_rd, exp_rd);
    chk("stat_wr", stat_wr, exp_wr);
    chk("stat_rp_stall", stat_rp_stall, exp_stall);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
